// File: rtl/mma_arb_if.sv
// mma_arb_if: groups the requester, engine and response signals of mma_arb.
// master modport = arbiter side; slave modport = requesters, engine and response sink.
// Ports: req_valid/req_ready/req_a/req_b, eng_start/eng_a/eng_b/eng_done/eng_result,
//        rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err, busy.
interface mma_arb_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*N*WIDTH-1:0] req_a;
  logic [NREQ*N*WIDTH-1:0] req_b;

  logic                    eng_start;
  logic [N*WIDTH-1:0]      eng_a;
  logic [N*WIDTH-1:0]      eng_b;
  logic                    eng_done;
  logic [2*WIDTH-1:0]      eng_result;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [2*WIDTH-1:0]      rsp_data;
  logic                    rsp_err;

  logic                    busy;

  modport master (
    input  req_valid, req_a, req_b, eng_done, eng_result, rsp_ready,
    output req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    output req_valid, req_a, req_b, eng_done, eng_result, rsp_ready,
    input  req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/mma_arb.sv
// mma_arb: round-robin arbiter feeding one dot-product engine, one job in flight at a time.
// Latency: accept cycle 0, eng_start cycle 1, eng_done earliest cycle 2, rsp_valid cycle 3.
// Backpressure: response held until rsp_ready; no requester is accepted while a job is in flight.
// Ports: clk, rst_n (async active-low), bus (mma_arb_if.master: requester, engine, response, busy).
// Optional: define MMA_ARB_TIMEOUT_EN to enable the TIMEOUT-cycle engine watchdog
// (error response with rsp_data=0); without it rsp_err is tied low and TIMEOUT has no effect.
module mma_arb #(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mma_arb_if.master bus
);
  localparam int NW  = N * WIDTH;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mma_arb: TIMEOUT must be at least 1");
  end

  logic [1:0]         state;
  logic [IDW-1:0]     last_grant;
  logic [IDW-1:0]     id_q;
  logic [NW-1:0]      a_q;
  logic [NW-1:0]      b_q;
  logic [2*WIDTH-1:0] data_q;

  logic [IDW-1:0]     gnt_idx;
  logic [IDW-1:0]     cand;
  logic               gnt_found;
  logic               wd_expire;
  logic [NW-1:0]      a_arr [NREQ];
  logic [NW-1:0]      b_arr [NREQ];

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      a_arr[r] = bus.req_a[r*NW +: NW];
      b_arr[r] = bus.req_b[r*NW +: NW];
    end
  end

  // Scan from last_grant+1 around the ring; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_grant) + i) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Gated by rst_n so a requester never sees an accept while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && (state == S_IDLE) && gnt_found) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign bus.eng_start = (state == S_ISSUE);
  assign bus.eng_a     = a_q;
  assign bus.eng_b     = b_q;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.busy      = (state != S_IDLE);

`ifdef MMA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // wd_cnt equals the number of WAIT cycles already spent without eng_done.
  assign wd_expire   = (state == S_WAIT) && (wd_cnt == CW'(TIMEOUT - 1));
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wd_cnt <= '0;
      end else if ((state == S_WAIT) && !wd_expire) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if (state == S_WAIT) begin
        if (bus.eng_done)   err_q <= 1'b0;
        else if (wd_expire) err_q <= 1'b1;
      end
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            id_q  <= gnt_idx;
            a_q   <= a_arr[gnt_idx];
            b_q   <= b_arr[gnt_idx];
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // eng_done has priority over a watchdog expiring in the same cycle.
          if (bus.eng_done) begin
            data_q <= bus.eng_result;
            state  <= S_RESP;
          end else if (wd_expire) begin
            data_q <= '0;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            last_grant <= id_q;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mma_arb.md
MMA_ARB -- requirements
Module: mma_arb

Interface
REQ-001 SHALL provide parameter N, default 4, meaning elements per operand vector.
REQ-002 SHALL provide parameter WIDTH, default 8, meaning bits per operand element.
REQ-003 SHALL provide parameter NREQ, default 2, meaning number of requesters.
REQ-004 SHALL provide parameter TIMEOUT, default 16, meaning the engine watchdog limit in cycles.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Port clk  in  1  the clock; all state changes on its rising edge.
REQ-007 Port rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port req_valid  in  NREQ  per-requester job valid.
REQ-009 Port req_ready  out  NREQ  per-requester job accept.
REQ-010 Port req_a  in  NREQ*N*WIDTH  operand A vectors; requester r in slice r*N*WIDTH.
REQ-011 Port req_b  in  NREQ*N*WIDTH  operand B vectors; same packing as req_a.
REQ-012 Port eng_start  out  1  dot-product engine start pulse.
REQ-013 Port eng_a, eng_b  out  N*WIDTH each  operand vectors driven to the engine.
REQ-014 Port eng_done  in  1  engine completion pulse.
REQ-015 Port eng_result  in  2*WIDTH  engine result, valid with eng_done.
REQ-016 Port rsp_valid  out  1, rsp_ready  in  1  response handshake.
REQ-017 Port rsp_id  out  clog2(NREQ) (min 1), rsp_data  out  2*WIDTH, rsp_err  out  1  response fields.
REQ-018 Port busy  out  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE: if any req_valid is high, SHALL grant the first valid requester in round-robin order starting at last_grant+1 (mod NREQ).
REQ-021 IDLE: SHALL assert req_ready[g] combinationally for the granted requester only, capture its req_a/req_b and id, and go to ISSUE.
REQ-022 ISSUE: eng_start SHALL be high for exactly one cycle; the FSM then goes to WAIT.
REQ-023 eng_a/eng_b SHALL hold the captured operands from ISSUE until the FSM leaves WAIT.
REQ-024 WAIT: on eng_done, SHALL capture eng_result into rsp_data, clear rsp_err and go to RESP.
REQ-025 eng_done SHALL be ignored in every state except WAIT.
REQ-026 RESP: SHALL hold rsp_valid high with stable rsp_id, rsp_data and rsp_err until rsp_ready is high.
REQ-027 RESP: on rsp_ready, SHALL set last_grant to rsp_id and return to IDLE; a new grant is possible no earlier than the following cycle.
REQ-028 Minimum latency SHALL be: accept at cycle 0, eng_start at cycle 1, eng_done at earliest cycle 2, rsp_valid at cycle 3.
REQ-029 A requester that drops req_valid before it is granted SHALL NOT be granted.
REQ-030 Requests arriving outside IDLE SHALL wait, with req_ready low.
REQ-031 Simultaneous requests SHALL be serviced strictly in rotation; no requester waits more than NREQ-1 jobs.

Reset
REQ-032 Asserting rst_n low SHALL, at any time including mid-job, force IDLE and drive req_ready, eng_start, rsp_valid, rsp_err and busy to 0 and clear rsp_data, rsp_id, eng_a and eng_b.
REQ-033 Reset SHALL set last_grant to NREQ-1, so that requester 0 has first priority, and SHALL clear the watchdog counter.

Configuration
REQ-034 Macro MMA_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT; if eng_done is absent for TIMEOUT cycles after entry to WAIT, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-035 Macro MMA_ARB_TIMEOUT_EN defined: an eng_done arriving after that timeout SHALL be ignored.
REQ-036 Macro MMA_ARB_TIMEOUT_EN undefined: WAIT SHALL last until eng_done, rsp_err SHALL be tied to 0, and the TIMEOUT parameter SHALL be unused.

Verification
REQ-037 Single job: requester 0 sends a = b = {1,2,3,4}; engine returns 30 two cycles after start -> rsp_valid with rsp_id=0, rsp_data=30, rsp_err=0; eng_start high for exactly 1 cycle.
REQ-038 Contention: both requesters valid continuously for 4 jobs -> grant order 0,1,0,1 and req_ready one-hot.
REQ-039 Backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable, req_ready low throughout, grant follows release.
REQ-040 Reset mid-job: rst_n low during WAIT -> all outputs 0 immediately; a later eng_done is ignored; the next grant goes to requester 0.
REQ-041 Timeout with MMA_ARB_TIMEOUT_EN, TIMEOUT=16: engine never responds -> rsp_err=1 and rsp_data=0, 16 cycles after WAIT entry; a late eng_done produces no second response.
REQ-042 Stray pulse: eng_done pulsed in IDLE -> no rsp_valid.
